addsub_rr_sched: RTL and testbench

//   Round-robin scheduler that shares one 16-bit Adder_Sub instance among NREQ requesters.

---
 rtl/addsub_rr_sched.sv | 163 ++++++++++++++++
 tb/tb_addsub_rr_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_rr_sched.sv
// ---------------------------------------------------------------------------
// addsub_rr_sched
//   Round-robin scheduler that time-shares a single 16-bit add/sub datapath
//   among NREQ requesters. A winner is picked in IDLE and its operands are
//   registered. The shared adder is evaluated in EXEC. The 17-bit result is
//   then held in RESP, together with the winner's ID, until the consumer
//   accepts it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester "op pending"
//   req_ready  per-requester accept strobe (one-hot or zero, IDLE only)
//   req_sub    per-requester op select: 1 = A-B, 0 = A+B
//   req_a      packed operand A, requester i at [16*i +: 16]
//   req_b      packed operand B, same packing
//   rsp_valid  result available
//   rsp_ready  consumer accepts result
//   rsp_id     index of the requester owning the result
//   rsp_sum    17-bit result; bit 16 = carry (add) or borrow (sub)
// ---------------------------------------------------------------------------
module addsub_rr_sched #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_sub,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [16:0]          rsp_sum
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [16:0]    sum_q, sum_d;
  logic           valid_q, valid_d;
  logic           sub_q, sub_d;
  logic [15:0]    a_q, a_d;
  logic [15:0]    b_q, b_d;

  // Unpacked views of the operand buses
  logic [15:0] req_a_arr [NREQ];
  logic [15:0] req_b_arr [NREQ];

  // Candidate gi is the requester at offset gi+1 after the last grant
  logic [IDW-1:0] cand_idx [NREQ];
  logic [NREQ-1:0] cand_hit;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_a_arr[gi] = req_a[16*gi +: 16];
      assign req_b_arr[gi] = req_b[16*gi +: 16];
      assign cand_idx[gi]  = IDW'((int'(ptr_q) + gi + 1) % NREQ);
      assign cand_hit[gi]  = req_valid[cand_idx[gi]];
    end
  endgenerate

  // Lowest rotation offset with a pending request wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_found && cand_hit[k]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  // Accept strobe is combinational and gated by reset so nothing is
  // accepted while rst_n is held low (state already reads IDLE then).
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = rst_n && (state_q == IDLE) && grant_found &&
                             (grant_idx == IDW'(gi));
    end
  endgenerate

  // Shared Adder_Sub datapath: two's complement via B^sub with carry-in=sub.
  // For subtraction the raw carry is "no borrow", so it is inverted to
  // report a borrow in bit 16.
  logic [16:0] adder_raw;
  logic [16:0] adder_sum;
  assign adder_raw = {1'b0, a_q} + {1'b0, b_q ^ {16{sub_q}}} + {16'd0, sub_q};
  assign adder_sum = {adder_raw[16] ^ sub_q, adder_raw[15:0]};

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    sum_d   = sum_q;
    valid_d = valid_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          sub_d   = req_sub[grant_idx];
          a_d     = req_a_arr[grant_idx];
          b_d     = req_b_arr[grant_idx];
          ptr_d   = grant_idx;
          id_d    = grant_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        sum_d   = adder_sum;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= IDW'(NREQ - 1);
      id_q    <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;

endmodule

// File: tb/tb_addsub_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_addsub_rr_sched
//   Scoreboard bench. Ops are queued per requester. A driver presents them
//   and holds each one until it is accepted. A negedge monitor predicts every
//   grant from a plain round-robin model, pushes the arithmetic result, and
//   pops/compares on each response handshake.
// ---------------------------------------------------------------------------
module tb_addsub_rr_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid, req_ready, req_sub;
  logic [16*NREQ-1:0]  req_a, req_b;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [16:0]         rsp_sum;

  always #5 clk = ~clk;

  addsub_rr_sched #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum)
  );

  typedef struct packed { logic [15:0] a; logic [15:0] b; logic sub; } op_t;
  typedef struct packed { logic [IDW-1:0] id; logic [16:0] sum; } rsp_t;

  op_t  obuf [NREQ][64];
  int   wr_i [NREQ] = '{default: 0};
  int   rd_i [NREQ] = '{default: 0};
  rsp_t exp_q [$];

  int n_cmp = 0, n_bad = 0;
  bit busy = 1'b0;
  int last = NREQ - 1;
  int negcnt = 0, grant_neg = 0;
  bit prev_valid = 1'b0, hold_chk = 1'b0;
  logic [IDW-1:0] held_id;
  logic [16:0]    held_sum;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arithmetic: plain 17-bit modular add/subtract
  function automatic logic [16:0] ref_sum(logic [15:0] a, logic [15:0] b, logic sub);
    return sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
  endfunction

  function automatic int rr_pick(logic [NREQ-1:0] v, int from);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic post(int i, logic [15:0] a, logic [15:0] b, logic sub);
    obuf[i][wr_i[i] % 64] = '{a: a, b: b, sub: sub};
    wr_i[i]++;
  endtask

  function automatic bit drained();
    for (int i = 0; i < NREQ; i++) if (rd_i[i] != wr_i[i]) return 1'b0;
    return (req_valid == '0) && (exp_q.size() == 0) && !busy;
  endfunction

  task automatic wait_drain(int lim);
    int c = 0;
    while (!drained() && c < lim) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain", {31'd0, drained()}, 32'd1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    int w;
    logic [NREQ-1:0] exp_ready;
    rsp_t e;
    negcnt++;
    if (!rst_n) begin
      exp_q.delete();
      busy = 1'b0; last = NREQ - 1;
      prev_valid = 1'b0; hold_chk = 1'b0;
      check("rst_ready", {28'd0, req_ready}, 32'd0);
      check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    end else begin
      exp_ready = '0;
      w = -1;
      if (!busy) begin
        w = rr_pick(req_valid, last);
        if (w >= 0) exp_ready[w] = 1'b1;
      end
      check("grant", {28'd0, req_ready}, {28'd0, exp_ready});
      if (w >= 0) begin
        exp_q.push_back('{id: IDW'(w),
                          sum: ref_sum(req_a[16*w +: 16], req_b[16*w +: 16], req_sub[w])});
        last = w; busy = 1'b1; grant_neg = negcnt;
      end
      if (rsp_valid && !prev_valid)
        check("latency", negcnt - grant_neg, 32'd2);
      if (hold_chk) begin
        check("stall_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_id", {30'd0, rsp_id}, {30'd0, held_id});
        check("stall_sum", {15'd0, rsp_sum}, {15'd0, held_sum});
      end
      hold_chk = rsp_valid && !rsp_ready;
      held_id  = rsp_id;
      held_sum = rsp_sum;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", {30'd0, rsp_id}, {30'd0, e.id});
          check("rsp_sum", {15'd0, rsp_sum}, {15'd0, e.sum});
          $display("rsp id=%0d sum=0x%05h (expect id=%0d sum=0x%05h)", rsp_id, rsp_sum, e.id, e.sum);
        end
        busy = 1'b0;
      end
      prev_valid = rsp_valid;
    end
  end

  // Driver: presents queued ops, holds them until accepted, idles with junk operands
  initial begin
    logic [NREQ-1:0] acc;
    op_t o;
    req_valid = '0; req_sub = '0; req_a = '0; req_b = '0;
    forever begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) req_valid[i] = 1'b0;
        if (!req_valid[i]) begin
          if (rd_i[i] != wr_i[i]) begin
            o = obuf[i][rd_i[i] % 64];
            rd_i[i]++;
            req_valid[i] = 1'b1;
            req_a[16*i +: 16] = o.a;
            req_b[16*i +: 16] = o.b;
            req_sub[i] = o.sub;
          end else begin
            req_a[16*i +: 16] = 16'($urandom);
            req_b[16*i +: 16] = 16'($urandom);
            req_sub[i] = 1'($urandom);
          end
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_id", {30'd0, rsp_id}, 32'd0);
    check("reset_sum", {15'd0, rsp_sum}, 32'd0);
    rst_n = 1'b1;

    // Basic add on requester 0
    post(0, 16'h0003, 16'h0004, 1'b0);
    wait_drain(50);

    // Carry / borrow boundaries on requester 2
    post(2, 16'hFFFF, 16'h0001, 1'b0);
    post(2, 16'h0001, 16'h0002, 1'b1);
    post(2, 16'h0005, 16'h0005, 1'b1);
    wait_drain(100);

    // All requesters valid and held: strict rotation
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) post(i, rand16(), rand16(), 1'($urandom));
    wait_drain(200);

    // Consumer stall in RESP with other requests waiting
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    post(1, 16'h1234, 16'h0F0F, 1'b1);
    c = 0;
    while (!rsp_valid && c < 50) begin @(posedge clk); #1; c++; end
    check("stall_seen", {31'd0, rsp_valid}, 32'd1);
    post(0, 16'hAAAA, 16'h5555, 1'b0);
    post(2, 16'h0000, 16'h0001, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_drain(100);

    // Last grant 1, then only 1 and 3 valid: 3 wins, then 1
    post(1, 16'h0010, 16'h0001, 1'b0);
    wait_drain(50);
    post(1, 16'h0020, 16'h0002, 1'b1);
    post(3, 16'h0030, 16'h0003, 1'b0);
    wait_drain(100);

    // Reset while an op is in EXEC: op discarded, pointer restored
    post(1, 16'h7777, 16'h1111, 1'b0);
    c = 0;
    do begin @(negedge clk); c++; end while (!req_ready[1] && c < 50);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_id", {30'd0, rsp_id}, 32'd0);
    check("mid_rst_sum", {15'd0, rsp_sum}, 32'd0);
    post(2, 16'h0002, 16'h0002, 1'b0);
    post(0, 16'h0100, 16'h0001, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_drain(100);

    // Random traffic with random back-pressure
    for (int n = 0; n < 300; n++) begin
      int i;
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        i = $urandom_range(0, NREQ - 1);
        if (wr_i[i] - rd_i[i] < 50) post(i, rand16(), rand16(), 1'($urandom));
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_drain(5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
